// File: rtl/seg_scan_display_pkg.sv
// seg_display_pkg: shared mode encodings and fixed message glyphs for the seven-segment scanner.
// Segment words are {g,f,e,d,c,b,a}; bit 0 is segment a.
package seg_display_pkg;
    typedef enum logic [1:0] {
        MODE_HEX0  = 2'b00,
        MODE_HEX1  = 2'b01,
        MODE_MSG_A = 2'b10,
        MODE_MSG_B = 2'b11
    } mode_t;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [0:4][6:0] MSG_A = '{7'b1101101, 7'b1111000, 7'b0111111, 7'b1110000, 7'b1111001};
    localparam logic [0:4][6:0] MSG_B = '{7'b0001110, 7'b0111110, 7'b0110111, 7'b0110111, 7'b1110011};
endpackage

// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if: value/mode inputs and scanned segment outputs of the display controller.
// master drives wd/ins and observes seg/dig_en/frame_start; slave is the controller side.
interface seg_scan_display_if #(
    parameter int NUM_DIGITS = 5,
    parameter int DATA_W     = 8
);
    logic [DATA_W-1:0]     wd;
    logic [1:0]            ins;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] dig_en;
    logic                  frame_start;
    modport master (output wd, ins, input seg, dig_en, frame_start);
    modport slave  (input wd, ins, output seg, dig_en, frame_start);
endinterface

// File: rtl/seg_scan_display_font.sv
// hex_seg7_font: combinational 0-F seven-segment font.
// Ports: nib (4-bit value in), seg (7-bit pattern out, bit 0 = a, bit 6 = g, active-high).
module hex_seg7_font (
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    localparam logic [0:15][6:0] FONT = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };
    assign seg = FONT[nib];
endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed seven-segment controller showing hex data or blinking fixed messages.
// Ports: clk, rst (async, active-high); bus.slave carries wd/ins in and seg/dig_en/frame_start out.
// Mode and data are latched only when digit 0 is selected so a frame never mixes two values.
module seg_scan_display
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 5,
    parameter int DATA_W       = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 100
) (
    input logic              clk,
    input logic              rst,
    seg_scan_display_if.slave bus
);
    localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    logic [DW-1:0]     div;
    logic [IW-1:0]     idx, nidx;
    mode_t             mode_q, mode_n;
    logic [DATA_W-1:0] data_q, data_n, sh;
    logic [BW-1:0]     bcnt, bcnt_n;
    logic              blink_on, blink_n, tick, fs, stay, wrap;
    logic [3:0]        nib;
    logic [6:0]        hex_seg, pat;
    logic [2:0]        ci;
    hex_seg7_font u_font (.nib(nib), .seg(hex_seg));
    always_comb begin
        tick   = div == DW'(SCAN_DIV - 1);
        nidx   = idx == IW'(NUM_DIGITS - 1) ? '0 : idx + IW'(1);
        fs     = nidx == '0;
        // digit 0 uses the values being latched on this edge, not the old frame's
        mode_n = fs ? mode_t'(bus.ins) : mode_q;
        data_n = fs ? bus.wd : data_q;
        sh     = data_n << {nidx, 2'b00};
        nib    = sh[DATA_W-1 -: 4];
        ci     = 3'(nidx);
        // blink state only runs while message B stays latched across frames; any entry restarts it visible
        stay    = mode_n == MODE_MSG_B && mode_q == MODE_MSG_B;
        wrap    = bcnt == BW'(BLINK_FRAMES - 1);
        bcnt_n  = !fs ? bcnt : (!stay || wrap) ? '0 : bcnt + BW'(1);
        blink_n = !fs ? blink_on : !stay ? 1'b1 : blink_on ^ wrap;
        pat = !mode_n[1] ? (32'(nidx) < DATA_W / 4 ? hex_seg : SEG_BLANK) :
              32'(nidx) >= 5 ? SEG_BLANK :
              mode_n == MODE_MSG_A ? MSG_A[ci] :
              blink_n ? MSG_B[ci] : SEG_BLANK;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div             <= '0;
            idx             <= IW'(NUM_DIGITS - 1);
            mode_q          <= MODE_HEX0;
            data_q          <= '0;
            bcnt            <= '0;
            blink_on        <= 1'b1;
            bus.seg         <= '0;
            bus.dig_en      <= '0;
            bus.frame_start <= 1'b0;
        end else begin
            div             <= tick ? '0 : div + DW'(1);
            bus.frame_start <= 1'b0;
            if (tick) begin
                idx             <= nidx;
                mode_q          <= mode_n;
                data_q          <= data_n;
                bcnt            <= bcnt_n;
                blink_on        <= blink_n;
                bus.dig_en      <= NUM_DIGITS'(1) << nidx;
                bus.seg         <= pat;
                bus.frame_start <= fs;
            end
        end
    end
endmodule
